encoder_4x2_sync: RTL and testbench
===================================

Name: encoder_4x2_sync

Overview:
- Sequential 4-to-2 encoder, the inverse of the team's 2x4 decoder.
- Takes four asynchronous, bouncy request lines (buttons/switches on the FPGA board) and synchronizes and debounces each one.
- Priority-encodes the debounced vector to a 2-bit code, with the highest index winning, and presents it on a valid/ready handshake.
- Feeding its code into the 2x4 decoder reproduces the one-hot line that was pressed.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable clock cycles required before a debounced line changes (>=1).
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer (>=2).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  raw asynchronous request lines, active high.
- out_code  output  2  encoded index of the highest pressed line.
- out_multi  output  1  more than one line was pressed at capture.
- out_valid  output  1  code available; held until accepted.
- out_ready  input  1  consumer accepts the code when high together with out_valid.
- overrun  output  1  sticky; a new press was lost while busy.
- db_lines  output  4  debounced line state, for observation and LEDs.

Behaviour:
- Reset (rst_n=0, asynchronous): all synchronizer flops, debounce counters, db_lines, out_code, out_multi, out_valid and overrun go to 0; FSM goes to IDLE. The same applies mid-handshake; a pending code is discarded.
- Synchronizer: req[i] passes through SYNC_STAGES flops, giving s[i].
- Debounce, per line, counter width $clog2(DEBOUNCE_CYCLES+1):
  - If s[i]==db[i], the counter clears.
  - Otherwise the counter increments; when the counter equals DEBOUNCE_CYCLES-1 and s[i] still differs, db[i]<=s[i] and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is rejected.
- Encode: code = index of the highest set bit of db. multi = popcount(db)>1.
- FSM states:
  - IDLE: out_valid=0. If db!=0, register out_code and out_multi, clear overrun, and go to HOLD.
  - HOLD: out_valid=1. out_code and out_multi are stable. If out_ready=1, the transfer occurs this cycle and the FSM goes to WAIT_RELEASE (out_valid=0 next cycle). Otherwise it stays in HOLD.
  - WAIT_RELEASE: out_valid=0. When db==0, go to IDLE.
- Overrun: in HOLD or WAIT_RELEASE, any db bit rising 0->1 sets overrun. Overrun stays set until the next IDLE capture.
- Latency: a clean req edge reaches db after SYNC_STAGES+DEBOUNCE_CYCLES edges; out_valid rises one edge later. With the defaults this is 7 edges.
- Release and re-press of the same line is a new event only after passing through WAIT_RELEASE and IDLE; no auto-repeat.
- out_ready high while in IDLE or WAIT_RELEASE has no effect.

Decomposition:
- Shared package:
  - FSM state enum {IDLE, HOLD, WAIT_RELEASE} (2-bit).
  - Constant NUM_LINES=4 and CODE_W=2, also used by the 2x4 decoder.
  - Function prio_enc4 (vector -> code).
- One sub-module, debounce_cell: synchronizer plus counter for a single line, instantiated 4 times. The FSM and encoder stay in the top module.

Test Plan (defaults):
- Clean press: req=4'b0100 held from edge 0 -> db_lines=4'b0100 at edge 6, out_valid=1 with out_code=2'd2 and out_multi=0 at edge 7.
- Bounce rejection: req[1] pulsed high for 3 cycles, then low -> db_lines stays 0 and out_valid never asserts. Then a stable press of req[1] -> out_code=2'd1.
- Priority and multi: req=4'b1011 simultaneously -> out_code=2'd3, out_multi=1. Decoder fed out_code gives 4'b1000.
- Handshake stall: out_ready=0 for 10 cycles after valid -> out_valid and out_code held constant. Raise out_ready for 1 cycle -> out_valid falls next edge. Release req -> IDLE.
- Overrun: press req[0] and hold in HOLD, then press req[3] -> overrun=1. Accept, release all, press req[2] -> capture code 2'd2 and overrun cleared.
- Async reset mid-HOLD: rst_n low between edges -> out_valid, overrun and db_lines go to 0 immediately. After release with req=0, no output.

Source files
------------

// File: rtl/encoder_4x2_sync_pkg.sv
// Shared definitions for the 4-to-2 encoder and its companion 2x4 decoder.
// Holds line/code widths, the handshake FSM encoding and the priority encoder.
package encoder_4x2_sync_pkg;

  localparam int NUM_LINES = 4;
  localparam int CODE_W    = 2;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    HOLD         = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  // Highest set index wins; an all-zero vector encodes as 0.
  function automatic logic [CODE_W-1:0] prio_enc4(input logic [NUM_LINES-1:0] v);
    logic [CODE_W-1:0] code;
    code = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (v[i]) code = CODE_W'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/encoder_4x2_sync_debounce_cell.sv
// One request line: multi-flop synchronizer followed by a stability counter.
// The debounced level only follows the synchronized input after it has differed for DEBOUNCE_CYCLES cycles.
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  output logic db_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (s == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      db_d  = s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/encoder_4x2_sync.sv
// Debounced, priority-encoded button interface with a valid/ready output and an overrun flag.
// Handshake: a transfer happens on any rising clk edge where out_valid and out_ready are both 1;
// out_valid, out_code and out_multi stay stable from assertion until that edge.
module encoder_4x2_sync
  import encoder_4x2_sync_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LINES-1:0] req,
  output logic [CODE_W-1:0]    out_code,
  output logic                 out_multi,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun,
  output logic [NUM_LINES-1:0] db_lines,
  output logic [1:0]           dbg_state_o
);

  logic [NUM_LINES-1:0] db;
  logic [NUM_LINES-1:0] db_prev_q;
  logic [NUM_LINES-1:0] rise;
  state_t               state_q, state_d;
  logic [CODE_W-1:0]    code_q, code_d;
  logic                 multi_q, multi_d;
  logic                 ovr_q, ovr_d;
  logic                 capture;

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .req_i(req[g]),
      .db_o (db[g])
    );
  end

  assign rise    = db & ~db_prev_q;
  assign capture = (state_q == IDLE) && (db != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (db != '0) state_d = HOLD;
      HOLD:         if (out_ready) state_d = WAIT_RELEASE;
      WAIT_RELEASE: if (db == '0) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == HOLD);
  end

  // Any fresh press while a code is outstanding or not yet released counts as lost.
  always_comb begin
    code_d  = code_q;
    multi_d = multi_q;
    ovr_d   = ovr_q;
    if (capture) begin
      code_d  = prio_enc4(db);
      multi_d = ($countones(db) > 1);
      ovr_d   = 1'b0;
    end else if ((state_q == HOLD || state_q == WAIT_RELEASE) && (rise != '0)) begin
      ovr_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q    <= '0;
      multi_q   <= 1'b0;
      ovr_q     <= 1'b0;
      db_prev_q <= '0;
    end else begin
      code_q    <= code_d;
      multi_q   <= multi_d;
      ovr_q     <= ovr_d;
      db_prev_q <= db;
    end
  end

  assign out_code    = code_q;
  assign out_multi   = multi_q;
  assign overrun     = ovr_q;
  assign db_lines    = db;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_encoder_4x2_sync.sv
// Directed and randomized checks of the debounced 4-to-2 encoder against a behavioural model.
module tb_encoder_4x2_sync;
  import encoder_4x2_sync_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] out_code;
  logic       out_multi;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;
  logic [3:0] db_lines;
  logic [1:0] dbg_state;

  int tests = 0;
  int fails = 0;

  logic [2:0] exp_q[$];

  encoder_4x2_sync #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .out_code   (out_code),
    .out_multi  (out_multi),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .db_lines   (db_lines),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: the press maps to the index of its highest line, multi when several lines are down.
  function automatic logic [2:0] model(input logic [3:0] pat);
    int hi;
    hi = 0;
    for (int i = 0; i < 4; i++) if (pat[i]) hi = i;
    return {($countones(pat) > 1), 2'(hi)};
  endfunction

  function automatic logic [3:0] dec2x4(input logic [1:0] code);
    logic [3:0] one;
    one = 4'b0001;
    return one << code;
  endfunction

  task automatic press(input string tag, input logic [3:0] pat);
    int cyc;
    logic [2:0] e;
    req = pat;
    e = model(pat);
    exp_q.push_back(e);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 8'(cyc), 8'd7);
    check({tag, "_code"}, 8'(out_code), 8'(e[1:0]));
    check({tag, "_multi"}, 8'(out_multi), 8'(e[2]));
  endtask

  task automatic accept(input string tag);
    logic [2:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
    check({tag, "_acc_valid"}, 8'(out_valid), 8'd1);
    check({tag, "_acc_item"}, 8'({out_multi, out_code}), 8'(e));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_fall"}, 8'(out_valid), 8'd0);
  endtask

  task automatic release_all(input string tag);
    req = 4'b0000;
    repeat (8) tick();
    check({tag, "_idle"}, 8'(dbg_state), 8'(IDLE));
    check({tag, "_db_clear"}, 8'(db_lines), 8'd0);
  endtask

  initial begin
    logic       seen;
    logic [1:0] held_code;
    logic [3:0] pat;
    int         stall;
    int         gl_len;

    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    #12;
    check("rst_valid", 8'(out_valid), 8'd0);
    check("rst_code", 8'(out_code), 8'd0);
    check("rst_multi", 8'(out_multi), 8'd0);
    check("rst_overrun", 8'(overrun), 8'd0);
    check("rst_db", 8'(db_lines), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Clean press with exact edge timing.
    req = 4'b0100;
    exp_q.push_back(model(4'b0100));
    repeat (5) tick();
    check("clean_db_e5", 8'(db_lines), 8'd0);
    tick();
    check("clean_db_e6", 8'(db_lines), 8'b0100);
    check("clean_valid_e6", 8'(out_valid), 8'd0);
    tick();
    check("clean_valid_e7", 8'(out_valid), 8'd1);
    check("clean_code", 8'(out_code), 8'd2);
    check("clean_multi", 8'(out_multi), 8'd0);
    accept("clean");
    release_all("clean");

    // Three-cycle bounce is rejected, then a stable press goes through.
    req = 4'b0010;
    repeat (3) tick();
    req = 4'b0000;
    seen = 1'b0;
    repeat (10) begin
      tick();
      seen = seen | out_valid | (|db_lines);
    end
    check("bounce_rejected", 8'(seen), 8'd0);
    press("bounce_press", 4'b0010);
    accept("bounce_press");
    release_all("bounce_press");

    // Priority, multi and a 10-cycle stall.
    press("prio", 4'b1011);
    check("prio_dec", 8'(dec2x4(out_code)), 8'b1000);
    held_code = out_code;
    seen = 1'b0;
    repeat (10) begin
      tick();
      seen = seen | !out_valid | (out_code !== held_code);
    end
    check("stall_held", 8'(seen), 8'd0);
    accept("prio");
    release_all("prio");

    // Overrun: second press while holding, cleared only by the next capture.
    press("ovr_first", 4'b0001);
    req = 4'b1001;
    repeat (6) tick();
    check("ovr_not_yet", 8'(overrun), 8'd0);
    tick();
    tick();
    check("ovr_set", 8'(overrun), 8'd1);
    check("ovr_code_kept", 8'(out_code), 8'd0);
    accept("ovr_first");
    release_all("ovr_rel");
    check("ovr_sticky", 8'(overrun), 8'd1);
    press("ovr_next", 4'b0100);
    check("ovr_cleared", 8'(overrun), 8'd0);
    accept("ovr_next");
    release_all("ovr_next");

    // Asynchronous reset while holding with overrun set.
    press("arst", 4'b0001);
    req = 4'b0011;
    repeat (8) tick();
    check("arst_pre_ovr", 8'(overrun), 8'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 8'(out_valid), 8'd0);
    check("arst_overrun", 8'(overrun), 8'd0);
    check("arst_db", 8'(db_lines), 8'd0);
    exp_q.delete();
    req = 4'b0000;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      tick();
      seen = seen | out_valid | (|db_lines);
    end
    check("arst_quiet", 8'(seen), 8'd0);

    // Randomized presses, optional short glitches and stalls.
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        gl_len = $urandom_range(1, 3);
        req = 4'(1 << $urandom_range(0, 3));
        repeat (gl_len) tick();
        req = 4'b0000;
        seen = 1'b0;
        repeat (8) begin
          tick();
          seen = seen | out_valid | (|db_lines);
        end
        check("rnd_glitch", 8'(seen), 8'd0);
      end
      pat = 4'($urandom_range(1, 15));
      press("rnd", pat);
      stall = $urandom_range(0, 6);
      held_code = out_code;
      seen = 1'b0;
      repeat (stall) begin
        tick();
        seen = seen | !out_valid | (out_code !== held_code);
      end
      check("rnd_stall", 8'(seen), 8'd0);
      accept("rnd");
      release_all("rnd");
    end

    check("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
